sdram_init_seq: RTL and testbench
=================================

// Module: sdram_init_seq
// PURPOSE
//  Parametrised SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE ALL,
//  N auto-refreshes, LOAD MODE REGISTER, each command followed by its programmed wait.
//  Mode word and timing come from parameters, for any SDR part/clock.
//  Sits between the board SDRAM pins and the controller; ofin hands the bus to the controller.
// PARAMETERS
//  ADDR_W          13     DRAM_ADDR width (>=11)
//  BA_W            2      DRAM_BA width
//  DQ_W            16     DRAM_DQ width
//  CNT_W           16     wait counter width; must hold T_PWRUP_CYC
//  T_PWRUP_CYC     10000  NOP cycles after ireq before PRECHARGE (>=1)
//  T_RP_CYC        2      cycles from PRECHARGE issue to next command (>=1)
//  T_RFC_CYC       7      cycles from each REFRESH issue to next command (>=1)
//  T_MRD_CYC       2      cycles from LOAD MODE issue to ofin (>=1)
//  N_REFRESH       8      auto-refresh commands issued (1..255)
//  CAS_LAT         2      mode A[6:4]; 2 or 3 only
//  BURST_LEN_LOG2  3      mode A[2:0]; 0..3 (BL 1/2/4/8)
//  WB_SINGLE       1      mode A9 (1 = single-location write burst)
//  Illegal values -> $error at elaboration.
// PORTS
//  iclk        in   1       system clock
//  ctr_reset   in   1       reset, asynchronous, active-high
//  ireq        in   1       start request, level, sampled in IDLE
//  ienb        in   1       pin drive enable; 0 -> all DRAM_* outputs 'z
//  ofin        out  1       init complete (high in FIN only)
//  obusy       out  1       high in every state except IDLE and FIN
//  orefs       out  8       refreshes issued so far in current sequence
//  DRAM_CLK    out  1       ~iclk
//  DRAM_CKE    out  1       1
//  DRAM_ADDR   out  ADDR_W  registered address
//  DRAM_BA     out  BA_W    registered bank
//  DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out 1 each  registered command
//  DRAM_UDQM, DRAM_LDQM  out 1 each  both 1 throughout
//  DRAM_DQ     out  DQ_W    all 0
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, cmd NOP (0111), addr 0, ba 0, dqm 11, ofin 0, obusy 0, orefs 0.
//  - Commands {CS,RAS,CAS,WE}: NOP 0111, PALL 0010, REF 0001, MRS 0000. All pin values registered;
//    the value for a state appears in the same cycle the state register holds it.
//  - States: IDLE, PWRUP, PRE, WAIT_RP, REF, WAIT_RFC, LOAD, WAIT_MRD, FIN.
//  - IDLE: NOP; ireq=1 -> PWRUP, load counter.
//  - PWRUP: NOP for exactly T_PWRUP_CYC cycles -> PRE.
//  - PRE: 1 cycle PALL, A10=1, other addr bits 0, ba 0 -> WAIT_RP (NOP, T_RP_CYC-1 cycles; skipped if 0) -> REF.
//  - REF: 1 cycle REF, orefs+1 -> WAIT_RFC (NOP, T_RFC_CYC-1 cycles) -> REF if orefs<N_REFRESH, else LOAD.
//  - LOAD: 1 cycle MRS, ba 0, addr = {0, WB_SINGLE@A9, 00@A8:7, CAS_LAT@A6:4, 0@A3, BURST_LEN_LOG2@A2:0};
//    defaults -> 13'h0223. -> WAIT_MRD (NOP, T_MRD_CYC-1 cycles) -> FIN.
//  - FIN: NOP, ofin=1, orefs holds N_REFRESH.
//  - Latency: ofin rises 1+T_PWRUP_CYC+T_RP_CYC+N_REFRESH*T_RFC_CYC+T_MRD_CYC cycles after ireq sampled.
//  - ireq dropped or re-asserted mid-sequence: ignored; sequence runs to FIN.
//  - ienb affects pin tri-state only; FSM and counters run regardless.
//  - ctr_reset mid-sequence: immediate return to reset values; a new ireq restarts from PWRUP.
//  - Counter never wraps; it counts down to 0, then reloads on transition.
// CONFIGURATION
//  SDRAM_INIT_REINIT_EN defined: ireq=1 in FIN -> PRE (power-up wait skipped), orefs cleared,
//    ofin low the next cycle; full PRE/REF/LOAD sequence repeats.
//  Undefined: FIN is terminal; ireq ignored until ctr_reset.
// TESTING
//  1 Small params (T_PWRUP 20, T_RP 2, N 2, T_RFC 4, T_MRD 2), ireq pulse -> ofin at cycle 33,
//    command trace NOP x21, PALL, NOP, REF, NOP x3, REF, NOP x3, MRS, NOP, then FIN.
//  2 Defaults: MRS cycle shows DRAM_ADDR=13'h0223, ba=0; PALL cycle shows DRAM_ADDR[10]=1.
//  3 ienb=0 throughout -> all DRAM_* 'z; ofin still rises at the same cycle as test 1.
//  4 ctr_reset asserted during WAIT_RFC -> outputs reset asynchronously, orefs=0;
//    new ireq -> full sequence, ofin at 33.
//  5 ireq toggled during PWRUP and REF -> trace identical to test 1.
//  6 With SDRAM_INIT_REINIT_EN, ireq in FIN -> PALL next cycle, ofin rises 13 cycles later;
//    without it, no command change.

Source files
------------

// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up initialisation sequencer: NOP wait, PRECHARGE ALL, N auto-refreshes, LOAD MODE.
// Optional feature macro SDRAM_INIT_REINIT_EN: ireq in FIN re-runs the PRE/REF/LOAD part of the sequence.
module sdram_init_seq #(
  parameter int ADDR_W         = 13,
  parameter int BA_W           = 2,
  parameter int DQ_W           = 16,
  parameter int CNT_W          = 16,
  parameter int T_PWRUP_CYC    = 10000,
  parameter int T_RP_CYC       = 2,
  parameter int T_RFC_CYC      = 7,
  parameter int T_MRD_CYC      = 2,
  parameter int N_REFRESH      = 8,
  parameter int CAS_LAT        = 2,
  parameter int BURST_LEN_LOG2 = 3,
  parameter int WB_SINGLE      = 1
) (
  input  logic              iclk,
  input  logic              ctr_reset,
  input  logic              ireq,
  input  logic              ienb,
  output logic              ofin,
  output logic              obusy,
  output logic [7:0]        orefs,
  output logic              DRAM_CLK,
  output logic              DRAM_CKE,
  output logic [ADDR_W-1:0] DRAM_ADDR,
  output logic [BA_W-1:0]   DRAM_BA,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic              DRAM_UDQM,
  output logic              DRAM_LDQM,
  output logic [DQ_W-1:0]   DRAM_DQ
);

  if (ADDR_W < 11) begin : g_bad_addr_w
    $error("sdram_init_seq: ADDR_W must be >= 11");
  end
  if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_bad_cas
    $error("sdram_init_seq: CAS_LAT must be 2 or 3");
  end
  if (BURST_LEN_LOG2 < 0 || BURST_LEN_LOG2 > 3) begin : g_bad_bl
    $error("sdram_init_seq: BURST_LEN_LOG2 must be 0..3");
  end
  if (WB_SINGLE < 0 || WB_SINGLE > 1) begin : g_bad_wb
    $error("sdram_init_seq: WB_SINGLE must be 0 or 1");
  end
  if (N_REFRESH < 1 || N_REFRESH > 255) begin : g_bad_nref
    $error("sdram_init_seq: N_REFRESH must be 1..255");
  end
  if (T_PWRUP_CYC < 1 || T_RP_CYC < 1 || T_RFC_CYC < 1 || T_MRD_CYC < 1) begin : g_bad_t
    $error("sdram_init_seq: all T_*_CYC parameters must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31 || T_PWRUP_CYC > (1 << CNT_W)) begin : g_bad_cnt
    $error("sdram_init_seq: CNT_W too small for T_PWRUP_CYC");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC, S_LOAD, S_WAIT_MRD, S_FIN
  } state_t;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam logic [ADDR_W-1:0] PALL_ADDR = ADDR_W'(11'h400);
  localparam logic [9:0] MODE_LO = {WB_SINGLE[0], 2'b00, CAS_LAT[2:0], 1'b0, BURST_LEN_LOG2[2:0]};
  localparam logic [ADDR_W-1:0] MODE_WORD = ADDR_W'(MODE_LO);

  // Each wait state covers T-1 cycles after its one-cycle command; T == 1 skips the wait state.
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] RP_LD    = CNT_W'((T_RP_CYC  > 1) ? T_RP_CYC  - 2 : 0);
  localparam logic [CNT_W-1:0] RFC_LD   = CNT_W'((T_RFC_CYC > 1) ? T_RFC_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] MRD_LD   = CNT_W'((T_MRD_CYC > 1) ? T_MRD_CYC - 2 : 0);
  localparam logic [7:0]       N_REF_V  = N_REFRESH[7:0];

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             cnt_zero_s;
  logic             more_refs_s;
  logic [3:0]       cmd_r;
  logic [ADDR_W-1:0] addr_r;
  logic [BA_W-1:0]  ba_r;
  logic             ofin_r;
  logic             obusy_r;
  logic [7:0]       orefs_r;

  function automatic logic [3:0] cmd_of(input state_t s);
    case (s)
      S_PRE:   cmd_of = CMD_PALL;
      S_REF:   cmd_of = CMD_REF;
      S_LOAD:  cmd_of = CMD_MRS;
      default: cmd_of = CMD_NOP;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input state_t s);
    case (s)
      S_PRE:   addr_of = PALL_ADDR;
      S_LOAD:  addr_of = MODE_WORD;
      default: addr_of = {ADDR_W{1'b0}};
    endcase
  endfunction

  assign cnt_zero_s  = (cnt_r == {CNT_W{1'b0}});
  assign more_refs_s = (orefs_r < N_REF_V);

  // Next-state and wait-counter selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (ireq) begin
          state_nxt_s = S_PWRUP;
          cnt_nxt_s   = PWRUP_LD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PWRUP: begin
        if (cnt_zero_s) state_nxt_s = S_PRE;
        else            cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_PRE: begin
        if (T_RP_CYC > 1) begin
          state_nxt_s = S_WAIT_RP;
          cnt_nxt_s   = RP_LD;
        end else begin
          state_nxt_s = S_REF;
        end
      end
      S_WAIT_RP: begin
        if (cnt_zero_s) state_nxt_s = S_REF;
        else            cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_REF: begin
        if (T_RFC_CYC > 1) begin
          state_nxt_s = S_WAIT_RFC;
          cnt_nxt_s   = RFC_LD;
        end else begin
          state_nxt_s = more_refs_s ? S_REF : S_LOAD;
        end
      end
      S_WAIT_RFC: begin
        if (cnt_zero_s) state_nxt_s = more_refs_s ? S_REF : S_LOAD;
        else            cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_LOAD: begin
        if (T_MRD_CYC > 1) begin
          state_nxt_s = S_WAIT_MRD;
          cnt_nxt_s   = MRD_LD;
        end else begin
          state_nxt_s = S_FIN;
        end
      end
      S_WAIT_MRD: begin
        if (cnt_zero_s) state_nxt_s = S_FIN;
        else            cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_FIN: begin
`ifdef SDRAM_INIT_REINIT_EN
        if (ireq) state_nxt_s = S_PRE;
        else      state_nxt_s = S_FIN;
`else
        state_nxt_s = S_FIN;
`endif
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register; pin and status registers are decoded from the next state so they line up with it.
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      cmd_r   <= CMD_NOP;
      addr_r  <= {ADDR_W{1'b0}};
      ba_r    <= {BA_W{1'b0}};
      ofin_r  <= 1'b0;
      obusy_r <= 1'b0;
      orefs_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cmd_r   <= cmd_of(state_nxt_s);
      addr_r  <= addr_of(state_nxt_s);
      ba_r    <= {BA_W{1'b0}};
      ofin_r  <= (state_nxt_s == S_FIN);
      obusy_r <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_FIN);
      if (state_nxt_s == S_REF)
        orefs_r <= orefs_r + 8'd1;
      else if (state_r == S_FIN && state_nxt_s == S_PRE)
        orefs_r <= 8'd0;
      else
        orefs_r <= orefs_r;
    end
  end

  assign ofin  = ofin_r;
  assign obusy = obusy_r;
  assign orefs = orefs_r;

  assign DRAM_CLK   = ienb ? ~iclk      : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1       : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_r     : {ADDR_W{1'bz}};
  assign DRAM_BA    = ienb ? ba_r       : {BA_W{1'bz}};
  assign DRAM_CS_N  = ienb ? cmd_r[3]   : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_r[2]   : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_r[1]   : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_r[0]   : 1'bz;
  assign DRAM_UDQM  = ienb ? 1'b1       : 1'bz;
  assign DRAM_LDQM  = ienb ? 1'b1       : 1'bz;
  assign DRAM_DQ    = ienb ? {DQ_W{1'b0}} : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq with shortened timing and default mode-register parameters.
module tb_sdram_init_seq;

  localparam int T_PWRUP = 20;
  localparam int T_RP    = 2;
  localparam int T_RFC   = 4;
  localparam int T_MRD   = 2;
  localparam int N_REF   = 2;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PALL = 4'b0010;
  localparam logic [3:0] REF  = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic iclk = 1'b0;
  logic ctr_reset;
  logic ireq;
  logic ienb;
  wire        ofin, obusy;
  wire [7:0]  orefs;
  wire        DRAM_CLK, DRAM_CKE;
  wire [12:0] DRAM_ADDR;
  wire [1:0]  DRAM_BA;
  wire        DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
  wire        DRAM_UDQM, DRAM_LDQM;
  wire [15:0] DRAM_DQ;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        fin;
    logic        busy;
    logic [7:0]  refs;
    logic        chk_addr;
    logic [12:0] addr;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  sdram_init_seq #(
    .ADDR_W(13), .BA_W(2), .DQ_W(16), .CNT_W(16),
    .T_PWRUP_CYC(T_PWRUP), .T_RP_CYC(T_RP), .T_RFC_CYC(T_RFC), .T_MRD_CYC(T_MRD),
    .N_REFRESH(N_REF), .CAS_LAT(2), .BURST_LEN_LOG2(3), .WB_SINGLE(1)
  ) dut (
    .iclk(iclk), .ctr_reset(ctr_reset), .ireq(ireq), .ienb(ienb),
    .ofin(ofin), .obusy(obusy), .orefs(orefs),
    .DRAM_CLK(DRAM_CLK), .DRAM_CKE(DRAM_CKE), .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA),
    .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N), .DRAM_WE_N(DRAM_WE_N),
    .DRAM_UDQM(DRAM_UDQM), .DRAM_LDQM(DRAM_LDQM), .DRAM_DQ(DRAM_DQ)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push(input logic [3:0] cmd, input logic fin, input int refs,
                      input logic chk_addr, input logic [12:0] addr);
    exp_t e;
    e.cmd      = cmd;
    e.fin      = fin;
    e.busy     = ~fin;
    e.refs     = 8'(refs);
    e.chk_addr = chk_addr;
    e.addr     = addr;
    sb.push_back(e);
  endtask

  // Expected per-cycle trace from the first cycle after ireq is sampled up to and including FIN.
  task automatic push_seq(input bit with_pwrup);
    if (with_pwrup)
      for (int i = 0; i < T_PWRUP; i++) push(NOP, 1'b0, 0, 1'b0, 13'h0);
    push(PALL, 1'b0, 0, 1'b1, 13'h0400);
    for (int i = 0; i < T_RP - 1; i++) push(NOP, 1'b0, 0, 1'b0, 13'h0);
    for (int r = 1; r <= N_REF; r++) begin
      push(REF, 1'b0, r, 1'b0, 13'h0);
      for (int i = 0; i < T_RFC - 1; i++) push(NOP, 1'b0, r, 1'b0, 13'h0);
    end
    push(MRS, 1'b0, N_REF, 1'b1, 13'h0223);
    for (int i = 0; i < T_MRD - 1; i++) push(NOP, 1'b0, N_REF, 1'b0, 13'h0);
    push(NOP, 1'b1, N_REF, 1'b0, 13'h0);
  endtask

  task automatic check_reset(input string tag);
    chk(tag, {1'b0, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, DRAM_ADDR, DRAM_BA,
              DRAM_UDQM, DRAM_LDQM, ofin, obusy, orefs},
             {1'b0, 4'b0111, 13'h0000, 2'b00, 2'b11, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic drain(input bit pins_on, input bit toggle, input int abort_at, input int exp_lat);
    int c = 0;
    int lat = 0;
    exp_t e;
    while (sb.size() > 0 && c < 200) begin
      @(negedge iclk);
      c++;
      e = sb.pop_front();
      if (pins_on) begin
        chk("trace", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N, ofin, obusy, orefs},
                     {e.cmd, e.fin, e.busy, e.refs});
        if (e.chk_addr) chk("addr", {DRAM_BA, DRAM_ADDR}, {2'b00, e.addr});
      end else begin
        chk("status", {ofin, obusy, orefs}, {e.fin, e.busy, e.refs});
        chk("released", {DRAM_CKE === 1'b1, DRAM_LDQM === 1'b1, DRAM_CS_N === 1'b1}, 3'b000);
      end
      if (ofin === 1'b1 && lat == 0) lat = c;
      ireq = (toggle && c < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == abort_at) begin
        ctr_reset = 1'b1;
        #1;
        check_reset("async_reset");
        sb.delete();
      end
    end
    chk("drained", sb.size(), 0);
    if (abort_at == 0) chk("latency", lat, exp_lat);
  endtask

  initial begin
    ctr_reset = 1'b1;
    ireq      = 1'b0;
    ienb      = 1'b1;
    repeat (3) @(negedge iclk);
    check_reset("reset");
    chk("static_pins", {DRAM_CKE, DRAM_DQ == 16'h0000, DRAM_CLK}, 3'b111);
    ctr_reset = 1'b0;
    repeat (2) @(negedge iclk);
    check_reset("idle_hold");

    // Basic sequence with a one-cycle request; PALL/MRS addresses checked on the way.
    ireq = 1'b1;
    push_seq(1'b1);
    drain(1'b1, 1'b0, 0, 33);

    // Pins released: FSM timing unaffected.
    ctr_reset = 1'b1;
    ienb      = 1'b0;
    @(negedge iclk);
    ctr_reset = 1'b0;
    @(negedge iclk);
    ireq = 1'b1;
    push_seq(1'b1);
    drain(1'b0, 1'b0, 0, 33);
    ienb = 1'b1;

    // Reset during the first refresh wait, then a fresh full sequence.
    ctr_reset = 1'b1;
    @(negedge iclk);
    ctr_reset = 1'b0;
    @(negedge iclk);
    ireq = 1'b1;
    push_seq(1'b1);
    drain(1'b1, 1'b0, 25, 0);
    @(negedge iclk);
    ctr_reset = 1'b0;
    ireq      = 1'b1;
    push_seq(1'b1);
    drain(1'b1, 1'b0, 0, 33);

    // Request toggling mid-sequence must not disturb the trace.
    ctr_reset = 1'b1;
    @(negedge iclk);
    ctr_reset = 1'b0;
    @(negedge iclk);
    ireq = 1'b1;
    push_seq(1'b1);
    drain(1'b1, 1'b1, 0, 33);

    // Request while in FIN.
    ireq = 1'b1;
`ifdef SDRAM_INIT_REINIT_EN
    push_seq(1'b0);
    drain(1'b1, 1'b0, 0, 13);
`else
    for (int i = 0; i < 13; i++) push(NOP, 1'b1, N_REF, 1'b0, 13'h0);
    drain(1'b1, 1'b0, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
